// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel window controller slice.
package sobel_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [63:0] win_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  // Neighbour packing order expected by sobel: p0 in the MSB byte, p8 in the LSB byte, centre omitted.
  function automatic win_t packNeighbours(
    input pixel_t p0, input pixel_t p1, input pixel_t p2, input pixel_t p3,
    input pixel_t p5, input pixel_t p6, input pixel_t p7, input pixel_t p8
  );
    return {p0, p1, p2, p3, p5, p6, p7, p8};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels, addressed by column; the read port shows the old contents so a
// write at the same address in the same cycle behaves as read-before-write.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
)
(
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pixel_t        i_wrData,
  output pixel_t        o_rdData
);

  pixel_t r_mem [DEPTH];

  assign o_rdData = r_mem[i_addr];

  // Storage is cleared on reset so a fresh frame never sees stale rows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wrData;
    end
  end

endmodule

// File: rtl/sobel.sv
// Combinational sobel magnitude |Gx|+|Gy| of a packed 3x3 neighbourhood, saturated to 8 bits.
module sobel
  import sobel_pkg::*;
(
  input  win_t   data,
  output pixel_t out
);

  pixel_t      w_p0, w_p1, w_p2, w_p3, w_p5, w_p6, w_p7, w_p8;
  logic [11:0] w_posX, w_negX, w_posY, w_negY;
  logic [11:0] w_gx, w_gy, w_absX, w_absY;
  logic [12:0] w_mag;

  // Gradients are formed as unsigned differences; bit 11 carries the sign since |G| never exceeds 1020.
  always_comb begin
    {w_p0, w_p1, w_p2, w_p3, w_p5, w_p6, w_p7, w_p8} = data;
    w_posX = {4'b0, w_p2} + {3'b0, w_p5, 1'b0} + {4'b0, w_p8};
    w_negX = {4'b0, w_p0} + {3'b0, w_p3, 1'b0} + {4'b0, w_p6};
    w_posY = {4'b0, w_p6} + {3'b0, w_p7, 1'b0} + {4'b0, w_p8};
    w_negY = {4'b0, w_p0} + {3'b0, w_p1, 1'b0} + {4'b0, w_p2};
    w_gx   = w_posX - w_negX;
    w_gy   = w_posY - w_negY;
    w_absX = w_gx[11] ? (12'd0 - w_gx) : w_gx;
    w_absY = w_gy[11] ? (12'd0 - w_gy) : w_gy;
    w_mag  = {1'b0, w_absX} + {1'b0, w_absY};
    out    = (w_mag > 13'd255) ? 8'hFF : w_mag[7:0];
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streams a raster-order frame through two line buffers and a 3x3 window into sobel,
// registering one magnitude per interior pixel onto a valid/ready output.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
)
(
  input  logic   clk,
  input  logic   n_rst,
  input  logic   start,
  input  pixel_t in_data,
  input  logic   in_valid,
  output logic   in_ready,
  output pixel_t out_data,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   busy,
  output logic   frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  state_t           r_state, w_nextState;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pixel_t           r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1;
  pixel_t           r_outData;
  logic             r_outValid, r_frameDone;
  pixel_t           w_lbaRd, w_lbbRd, w_sobelOut;
  win_t             w_sobelData;
  logic             w_inReady, w_busy, w_accept, w_produces, w_colWrap, w_lastPixel, w_fillEnd;

  assign w_accept    = in_valid && w_inReady;
  assign w_produces  = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_colWrap   = (r_col == LAST_COL);
  assign w_lastPixel = w_colWrap && (r_row == LAST_ROW);
  assign w_fillEnd   = (r_row == ROW_W'(2)) && (r_col == COL_W'(1));

  // lb_a shifts up from lb_b (row r-2), lb_b captures the incoming row (row r-1).
  line_buffer #(.DEPTH(IMG_W)) u_lbA (
    .clk(clk), .n_rst(n_rst), .i_we(w_accept), .i_addr(r_col),
    .i_wrData(w_lbbRd), .o_rdData(w_lbaRd)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lbB (
    .clk(clk), .n_rst(n_rst), .i_we(w_accept), .i_addr(r_col),
    .i_wrData(in_data), .o_rdData(w_lbbRd)
  );

  assign w_sobelData = packNeighbours(r_top1, r_top0, w_lbaRd, r_mid1, w_lbbRd, r_bot1, r_bot0, in_data);

  sobel u_sobel (
    .data(w_sobelData),
    .out (w_sobelOut)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: FILL ends on pixel (2,1), RUN ends on the last pixel, DONE waits for the final handshake.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = FILL;
      FILL:    if (w_accept && w_fillEnd) w_nextState = RUN;
      RUN:     if (w_accept && w_lastPixel) w_nextState = DONE;
      DONE:    if (!r_outValid || out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs: only producing pixels are held back by a stalled output register.
  always_comb begin
    w_inReady = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      IDLE:    w_busy    = 1'b0;
      FILL:    w_inReady = 1'b1;
      RUN:     w_inReady = !w_produces || !r_outValid || out_ready;
      default: w_inReady = 1'b0;
    endcase
  end

  // Raster position of the next pixel to arrive; restarts at the origin on every frame start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_colWrap ? '0 : r_col + 1'b1;
      if (w_colWrap) r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
    end
  end

  // Column shift registers holding the two previous columns of the three window rows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1} <= '0;
    end else if (w_accept) begin
      r_top1 <= r_top0;
      r_top0 <= w_lbaRd;
      r_mid1 <= r_mid0;
      r_mid0 <= w_lbbRd;
      r_bot1 <= r_bot0;
      r_bot0 <= in_data;
    end
  end

  // Output register: loads on a producing accept, otherwise drains on a handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else if (w_accept && w_produces) begin
      r_outData  <= w_sobelOut;
      r_outValid <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // frame_done pulses on the cycle after DONE sees its last handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_frameDone <= 1'b0;
    else        r_frameDone <= (r_state == DONE) && (w_nextState == IDLE);
  end

  assign in_ready   = w_inReady;
  assign busy       = w_busy;
  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: a 3x3 instance for the hand-computed window and a
// 64x48 instance for full frames, compared against an independent sobel reference.
module tb_sobel_window_ctrl;

  localparam int W = 64;
  localparam int H = 48;
  localparam int OUTS = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic       start, inValid, inReady, outValid, outReady, busy, frameDone;
  logic [7:0] inData, outData;
  logic       sStart, sInValid, sInReady, sOutValid, sOutReady, sBusy, sFrameDone;
  logic [7:0] sInData, sOutData;

  int checks = 0;
  int errors = 0;
  int outCnt, doneCnt, stallCnt, cyc, readyMode;
  logic [7:0] img [H][W];
  logic [7:0] expQ [$];

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady), .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .busy(busy), .frame_done(frameDone)
  );

  sobel_window_ctrl #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .start(sStart), .in_data(sInData), .in_valid(sInValid),
    .in_ready(sInReady), .out_data(sOutData), .out_valid(sOutValid), .out_ready(sOutReady),
    .busy(sBusy), .frame_done(sFrameDone)
  );

  // Reference sobel on a row-major 3x3 window, p0 in the top byte.
  function automatic logic [7:0] sobelRef(input logic [71:0] win);
    int gx, gy, v, mag;
    gx = 0;
    gy = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        v  = int'(win[71 - 8 * (dr * 3 + dc) -: 8]);
        gx += (dc - 1) * ((dr == 1) ? 2 : 1) * v;
        gy += (dr - 1) * ((dc == 1) ? 2 : 1) * v;
      end
    end
    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  function automatic logic [7:0] goldAt(input int cr, input int cc);
    logic [71:0] win;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        win[71 - 8 * (dr * 3 + dc) -: 8] = img[cr - 1 + dr][cc - 1 + dc];
    return sobelRef(win);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (readyMode)
      0:       outReady = 1'b1;
      1:       outReady = cyc[0];
      default: outReady = 1'b0;
    endcase
  endtask

  // Scoreboard: every valid cycle must show the queue head; a handshake retires it.
  always @(negedge clk) begin
    if (n_rst && outValid) begin
      checks++;
      assert (expQ.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_output observed %0h expected none", outData);
      end
      if (expQ.size() > 0) begin
        checkOutput("out_data", 64'(outData), 64'(expQ[0]));
        if (outReady) begin
          void'(expQ.pop_front());
          outCnt++;
        end
      end
    end
    if (n_rst && frameDone) doneCnt++;
  end

  task automatic applyStimulus(input int r, input int c);
    bit ok;
    ok = 1'b0;
    inValid = 1'b1;
    inData  = img[r][c];
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (inReady) begin
        if (r >= 2 && c >= 2) expQ.push_back(goldAt(r - 1, c - 1));
        tick();
        ok = 1'b1;
        break;
      end
      stallCnt++;
      tick();
    end
    if (!ok) checkOutput("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic runFrame(input int pattern, input int glitchIdx, input int stopIdx);
    bit seen;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pattern)
          0:       img[r][c] = 8'h80;
          1:       img[r][c] = 8'($urandom_range(0, 255));
          default: img[r][c] = (c < 32) ? 8'h00 : 8'hFF;
        endcase
    outCnt = 0;
    doneCnt = 0;
    stallCnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      if (i == stopIdx) return;
      if (i == glitchIdx) start = 1'b1;
      applyStimulus(i / W, i % W);
      start = 1'b0;
    end
    inValid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (frameDone) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("frame_done_seen", 64'(seen), 64'(1));
    checkOutput("busy_at_done", 64'(busy), 64'(0));
    checkOutput("queue_empty_at_done", 64'(expQ.size()), 64'(0));
    checkOutput("output_count", 64'(outCnt), 64'(OUTS));
    tick();
    @(negedge clk);
    checkOutput("frame_done_pulse", 64'(frameDone), 64'(0));
    checkOutput("done_count", 64'(doneCnt), 64'(1));
  endtask

  initial begin
    logic [7:0] vec [9];
    vec = '{8'h36, 8'hD2, 8'h14, 8'h45, 8'h00, 8'hDC, 8'h48, 8'hD2, 8'hFF};
    cyc = 0;
    readyMode = 0;
    n_rst = 1'b0;
    {start, inValid, inData, outReady} = '0;
    {sStart, sInValid, sInData} = '0;
    sOutReady = 1'b1;

    // Reset values
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(inReady), 64'(0));
    checkOutput("rst_out_data", 64'(outData), 64'(0));
    checkOutput("rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_frame_done", 64'(frameDone), 64'(0));
    tick();
    n_rst = 1'b1;
    tick();

    // 3x3 frame: single window with known packing
    sStart = 1'b1;
    tick();
    sStart = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sInValid = 1'b1;
      sInData  = vec[i];
      @(negedge clk);
      checkOutput("s_in_ready", 64'(sInReady), 64'(1));
      checkOutput("s_no_early_valid", 64'(sOutValid), 64'(0));
      if (i == 8) checkOutput("s_sobel_data", dut3.w_sobelData, 64'h36D21445DC48D2FF);
      tick();
    end
    sInValid = 1'b0;
    @(negedge clk);
    checkOutput("s_out_valid", 64'(sOutValid), 64'(1));
    checkOutput("s_out_data", 64'(sOutData), 64'(sobelRef(72'h36D2144500DC48D2FF)));
    checkOutput("s_done_early", 64'(sFrameDone), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("s_frame_done", 64'(sFrameDone), 64'(1));
    checkOutput("s_valid_cleared", 64'(sOutValid), 64'(0));
    checkOutput("s_busy_idle", 64'(sBusy), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("s_done_one_cycle", 64'(sFrameDone), 64'(0));

    // in_valid held in IDLE is not accepted
    inValid = 1'b1;
    inData  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_in_ready", 64'(inReady), 64'(0));
      checkOutput("idle_busy", 64'(busy), 64'(0));
      tick();
    end
    inValid = 1'b0;

    // Flat frame, no backpressure
    readyMode = 0;
    runFrame(0, -1, -1);
    checkOutput("flat_no_stall", 64'(stallCnt), 64'(0));

    // Random frame, toggling out_ready, stray start mid-frame
    readyMode = 1;
    runFrame(1, 700, -1);

    // Vertical edge frame
    readyMode = 0;
    runFrame(2, -1, -1);

    // Reset mid row 10 while an output is pending
    readyMode = 1;
    runFrame(1, -1, 10 * W + 20);
    readyMode = 2;
    outReady = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_valid", 64'(outValid), 64'(1));
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("mid_rst_out_data", 64'(outData), 64'(0));
    checkOutput("mid_rst_busy", 64'(busy), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(inReady), 64'(0));
    expQ.delete();
    tick();
    n_rst = 1'b1;
    readyMode = 0;
    tick();
    runFrame(1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
